// File: rtl/ext_pipe_if.sv
// Handshake bundle for the immediate extender: upstream valid/ready with the raw
// field and mode, downstream valid/ready with the extended operand.
interface ext_pipe_if #(
  parameter int OPERAND_WIDTH = 11,
  parameter int DATA_WIDTH    = 16
);
  logic                     in_valid;
  logic                     in_ready;
  logic [OPERAND_WIDTH-1:0] ext_in;
  logic [1:0]               ext_mode;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_WIDTH-1:0]    ext_out;
  logic                     ext_neg;

  modport master (
    output in_valid, ext_in, ext_mode, out_ready,
    input  in_ready, out_valid, ext_out, ext_neg
  );

  modport slave (
    input  in_valid, ext_in, ext_mode, out_ready,
    output in_ready, out_valid, ext_out, ext_neg
  );
endinterface

// File: rtl/ext_pipe.sv
// Two-stage, mode-selectable immediate extender between decode and the ALU
// operand mux. Modes: 00 sext long, 01 zext long, 10 sext short, 11 load-high.
module ext_pipe #(
  parameter int OPERAND_WIDTH = 11,
  parameter int SHORT_WIDTH   = 8,
  parameter int DATA_WIDTH    = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  ext_pipe_if.slave  bus
);
  localparam int W = OPERAND_WIDTH;
  localparam int S = SHORT_WIDTH;
  localparam int D = DATA_WIDTH;

  if (!(S >= 1 && S < W && W <= D)) begin : g_bad_params
    $error("ext_pipe: need 1 <= SHORT_WIDTH < OPERAND_WIDTH <= DATA_WIDTH");
  end

  logic         s1_valid_q;
  logic [W-1:0] s1_in_q;
  logic [1:0]   s1_mode_q;
  logic         out_valid_q;
  logic [D-1:0] ext_out_q;
  logic         ext_neg_q;
  logic [D-1:0] ext_d;
  logic         s1_en;
  logic         s2_en;

  assign s2_en        = !out_valid_q || bus.out_ready;
  assign s1_en        = !s1_valid_q || s2_en;
  assign bus.in_ready = s1_en;

  // Build each result by overlaying a slice on a filled word, so W == D never
  // needs a zero-width replication.
  always_comb begin
    ext_d = '0;
    unique case (s1_mode_q)
      2'b00: begin
        ext_d        = {D{s1_in_q[W-1]}};
        ext_d[W-1:0] = s1_in_q;
      end
      2'b01: ext_d[W-1:0] = s1_in_q;
      2'b10: begin
        ext_d        = {D{s1_in_q[S-1]}};
        ext_d[S-1:0] = s1_in_q[S-1:0];
      end
      default: ext_d[D-1 -: S] = s1_in_q[S-1:0];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_in_q     <= '0;
      s1_mode_q   <= 2'b00;
      out_valid_q <= 1'b0;
      ext_out_q   <= '0;
      ext_neg_q   <= 1'b0;
    end else begin
      if (s1_en) begin
        s1_valid_q <= bus.in_valid;
        // Data only moves with a valid item, keeping idle-bus X out of the regs.
        if (bus.in_valid) begin
          s1_in_q   <= bus.ext_in;
          s1_mode_q <= bus.ext_mode;
        end
      end
      if (s2_en) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          ext_out_q <= ext_d;
          ext_neg_q <= ext_d[D-1];
        end
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.ext_out   = ext_out_q;
  assign bus.ext_neg   = ext_neg_q;
endmodule
